id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection. Sits directly downstream of the
//  decode-stage control unit and register file, and registers their control bundle and operands
//  into EX. Inserts a one-cycle bubble on a load-use hazard, which also stalls PC and IF/ID.
//  Squashes its contents on a taken-branch flush, and counts inserted bubbles for debug.
// PARAMETERS
//  DATA_WIDTH  16  width of register operands, sign-extended immediate and PC+1
//  REG_AW       3  register-address width (rs/rt/rd fields)
//  CNT_WIDTH   16  width of saturating bubble counter
// PORTS
//  clk            in   1           rising-edge clock, single domain
//  rst            in   1           synchronous, active-high reset
//  id_ctrl_i      in   9           {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]}
//  id_rd1_i       in   DATA_WIDTH  register-file read data 1 (rs)
//  id_rd2_i       in   DATA_WIDTH  register-file read data 2 (rt)
//  id_imm_i       in   DATA_WIDTH  sign-extended immediate
//  id_pc1_i       in   DATA_WIDTH  PC+1 of decoding instruction
//  id_rs_i        in   REG_AW      rs field
//  id_rt_i        in   REG_AW      rt field
//  id_rd_i        in   REG_AW      rd field
//  id_uses_rt_i   in   1           decoding instruction reads rt as a source
//  hold_i         in   1           global freeze (e.g. memory wait): register keeps contents
//  flush_i        in   1           taken branch resolved downstream: squash ID instruction
//  ex_ctrl_o      out  9           registered control bundle, same bit order as id_ctrl_i
//  ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc1_o  out DATA_WIDTH  registered operands
//  ex_rs_o, ex_rt_o, ex_rd_o               out REG_AW      registered register fields
//  ex_valid_o     out  1           EX slot holds a real instruction (0 = bubble)
//  load_use_stall_o out 1          combinational; when 1, PC and IF/ID must not update this cycle
//  bubble_cnt_o   out  CNT_WIDTH   saturating count of inserted bubbles
// BEHAVIOUR
//  - Reset: all outputs clear to 0, including ex_ctrl_o, ex_valid_o and bubble_cnt_o.
//    Reset applies on the next clk edge, even mid-hazard or mid-hold.
//  - Hazard (combinational): haz = ex_ctrl_o[MemRead=bit4] & ex_valid_o & (ex_rt_o != 0) &
//    ((ex_rt_o == id_rs_i) | (id_uses_rt_i & ex_rt_o == id_rt_i)). Register 0 never causes a hazard.
//  - load_use_stall_o = haz & ~flush_i. A flush overrides the stall: the stalled instruction is dead.
//  - Per-edge update priority: rst > hold_i > flush_i > haz > normal.
//    hold_i: every register keeps its value; the counter does not count.
//    flush_i: ex_ctrl_o <= 0 and ex_valid_o <= 0. Data/field regs capture the inputs (don't-care).
//      No count.
//    haz: bubble. ex_ctrl_o <= 0 and ex_valid_o <= 0; data regs capture the inputs;
//      bubble_cnt_o += 1, saturating at all-ones.
//    normal: all fields capture the inputs; ex_valid_o <= 1.
//  - Latency: 1 cycle from ID inputs to EX outputs. After a bubble, ex_ctrl_o MemRead=0, so haz
//    drops and the stalled instruction advances on the following edge. Max stall per load is 1 cycle.
//  - Control-only bubble: a zeroed bundle is a NOP (RegWrite=MemWrite=MemRead=Branch=0,
//    ALUOp=00, matching opcode 000's ALUOp). Downstream must gate only on ctrl bits and ex_valid_o.
//  - While hold_i=1, load_use_stall_o still reflects haz. Upstream ORs it with hold_i.
// TESTING
//  1 rst=1 for 2 clk with random inputs -> every output 0; load_use_stall_o=0.
//  2 id_ctrl_i=9'b011110011, rd1=16'h1234, rt=3: one edge -> ex_ctrl_o=9'b011110011,
//    ex_rd1_o=16'h1234, ex_rt_o=3, ex_valid_o=1.
//  3 load in EX (MemRead=1, ex_rt_o=2), ID rs=2 -> stall=1; next edge ex_ctrl_o=0, cnt=1;
//    next edge ID instruction enters EX with valid=1.
//  4 as 3 but rt match with id_uses_rt_i=0, or ex_rt_o=0 -> stall=0, no bubble, cnt unchanged.
//  5 flush_i=1 together with haz -> stall=0, ex_ctrl_o=0, ex_valid_o=0, cnt unchanged;
//    hold_i=1 for 3 clk -> all outputs frozen.
//  6 CNT_WIDTH=2, 5 consecutive load-use pairs -> bubble_cnt_o 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// squashing and a saturating bubble counter for debug visibility.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_AW     = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8:0]            id_ctrl_i,
  input  logic [DATA_WIDTH-1:0] id_rd1_i,
  input  logic [DATA_WIDTH-1:0] id_rd2_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [DATA_WIDTH-1:0] id_pc1_i,
  input  logic [REG_AW-1:0]     id_rs_i,
  input  logic [REG_AW-1:0]     id_rt_i,
  input  logic [REG_AW-1:0]     id_rd_i,
  input  logic                  id_uses_rt_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic [8:0]            ex_ctrl_o,
  output logic [DATA_WIDTH-1:0] ex_rd1_o,
  output logic [DATA_WIDTH-1:0] ex_rd2_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [DATA_WIDTH-1:0] ex_pc1_o,
  output logic [REG_AW-1:0]     ex_rs_o,
  output logic [REG_AW-1:0]     ex_rt_o,
  output logic [REG_AW-1:0]     ex_rd_o,
  output logic                  ex_valid_o,
  output logic                  load_use_stall_o,
  output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

  // MemRead position inside the control bundle
  localparam int MEM_READ_BIT = 4;

  logic [8:0]            r_ctrl;
  logic [DATA_WIDTH-1:0] r_rd1;
  logic [DATA_WIDTH-1:0] r_rd2;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_pc1;
  logic [REG_AW-1:0]     r_rs;
  logic [REG_AW-1:0]     r_rt;
  logic [REG_AW-1:0]     r_rd;
  logic                  r_valid;
  logic [CNT_WIDTH-1:0]  r_bubble_cnt;

  logic w_haz;
  logic w_rs_match;
  logic w_rt_match;

  // Detect a load in EX whose destination (rt, never r0) feeds the decoding instruction
  always_comb begin
    w_rs_match = (r_rt == id_rs_i);
    w_rt_match = id_uses_rt_i && (r_rt == id_rt_i);
    w_haz      = r_ctrl[MEM_READ_BIT] && r_valid && (r_rt != '0) &&
                 (w_rs_match || w_rt_match);
  end

  // A flush kills the stalled instruction, so it also cancels the stall request
  assign load_use_stall_o = w_haz && !flush_i;

  // Register update with priority reset > hold > flush > hazard bubble > normal advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl       <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_pc1        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (hold_i) begin
      r_ctrl       <= r_ctrl;
      r_valid      <= r_valid;
      r_bubble_cnt <= r_bubble_cnt;
    end else begin
      r_rd1 <= id_rd1_i;
      r_rd2 <= id_rd2_i;
      r_imm <= id_imm_i;
      r_pc1 <= id_pc1_i;
      r_rs  <= id_rs_i;
      r_rt  <= id_rt_i;
      r_rd  <= id_rd_i;
      if (flush_i) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
      end else if (w_haz) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
        if (r_bubble_cnt != {CNT_WIDTH{1'b1}}) begin
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
      end else begin
        r_ctrl  <= id_ctrl_i;
        r_valid <= 1'b1;
      end
    end
  end

  assign ex_ctrl_o    = r_ctrl;
  assign ex_rd1_o     = r_rd1;
  assign ex_rd2_o     = r_rd2;
  assign ex_imm_o     = r_imm;
  assign ex_pc1_o     = r_pc1;
  assign ex_rs_o      = r_rs;
  assign ex_rt_o      = r_rt;
  assign ex_rd_o      = r_rd;
  assign ex_valid_o   = r_valid;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a driver pushes hand-computed expectations
// into queues and independent monitors pop and compare them against the DUT.
module tb_id_ex_pipe_reg;

  localparam logic [8:0] LD  = 9'b011110000;
  localparam logic [8:0] ALU = 9'b100100010;

  typedef struct {
    logic [8:0]  ctrl;
    logic [15:0] rd1, rd2, imm, pc1;
    logic [2:0]  rs, rt, rd;
    logic        valid;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  idCtrl = '0;
  logic [15:0] idRd1 = '0, idRd2 = '0, idImm = '0, idPc1 = '0;
  logic [2:0]  idRs = '0, idRt = '0, idRd = '0;
  logic        idUsesRt = 1'b0, hold = 1'b0, flush = 1'b0;

  logic [8:0]  exCtrl, exCtrl2;
  logic [15:0] exRd1, exRd2, exImm, exPc1, exRd1b, exRd2b, exImmb, exPc1b;
  logic [2:0]  exRs, exRt, exRd, exRsb, exRtb, exRdb;
  logic        exValid, exValid2, stall, stall2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int assertCount = 0;
  int failCount   = 0;

  exp_t outQ[$];
  bit   stallQ[$];
  exp_t prevExp;

  id_ex_pipe_reg #(.DATA_WIDTH(16), .REG_AW(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .id_ctrl_i(idCtrl), .id_rd1_i(idRd1), .id_rd2_i(idRd2),
    .id_imm_i(idImm), .id_pc1_i(idPc1), .id_rs_i(idRs), .id_rt_i(idRt), .id_rd_i(idRd),
    .id_uses_rt_i(idUsesRt), .hold_i(hold), .flush_i(flush), .ex_ctrl_o(exCtrl),
    .ex_rd1_o(exRd1), .ex_rd2_o(exRd2), .ex_imm_o(exImm), .ex_pc1_o(exPc1),
    .ex_rs_o(exRs), .ex_rt_o(exRt), .ex_rd_o(exRd), .ex_valid_o(exValid),
    .load_use_stall_o(stall), .bubble_cnt_o(cnt)
  );

  id_ex_pipe_reg #(.DATA_WIDTH(16), .REG_AW(3), .CNT_WIDTH(2)) dutSat (
    .clk(clk), .rst(rst), .id_ctrl_i(idCtrl), .id_rd1_i(idRd1), .id_rd2_i(idRd2),
    .id_imm_i(idImm), .id_pc1_i(idPc1), .id_rs_i(idRs), .id_rt_i(idRt), .id_rd_i(idRd),
    .id_uses_rt_i(idUsesRt), .hold_i(hold), .flush_i(flush), .ex_ctrl_o(exCtrl2),
    .ex_rd1_o(exRd1b), .ex_rd2_o(exRd2b), .ex_imm_o(exImmb), .ex_pc1_o(exPc1b),
    .ex_rs_o(exRsb), .ex_rt_o(exRtb), .ex_rd_o(exRdb), .ex_valid_o(exValid2),
    .load_use_stall_o(stall2), .bubble_cnt_o(cnt2)
  );

  // Free-running clock
  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT must show
  task automatic applyStimulus(input bit r, input bit h, input bit f, input bit rnd,
                               input logic [8:0] ctrl, input logic [2:0] rs,
                               input logic [2:0] rt, input logic [2:0] rd,
                               input bit usesRt, input logic [15:0] rd1,
                               input bit chkStall, input bit expStall,
                               input logic [8:0] expCtrl, input bit expValid,
                               input logic [15:0] expCnt, input logic [1:0] expCnt2);
    exp_t e;
    @(negedge clk);
    rst = r; hold = h; flush = f;
    if (rnd) begin
      idCtrl = 9'($urandom); idRd1 = 16'($urandom); idRd2 = 16'($urandom);
      idImm = 16'($urandom); idPc1 = 16'($urandom); idRs = 3'($urandom);
      idRt = 3'($urandom); idRd = 3'($urandom); idUsesRt = 1'($urandom);
    end else begin
      idCtrl = ctrl; idRd1 = rd1; idRd2 = rd1 ^ 16'h00FF; idImm = rd1 + 16'd1;
      idPc1 = rd1 + 16'd2; idRs = rs; idRt = rt; idRd = rd; idUsesRt = usesRt;
    end
    if (r) begin
      e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.pc1 = '0; e.rs = '0; e.rt = '0; e.rd = '0;
    end else if (h) begin
      e = prevExp;
    end else begin
      e.rd1 = idRd1; e.rd2 = idRd2; e.imm = idImm; e.pc1 = idPc1;
      e.rs = idRs; e.rt = idRt; e.rd = idRd;
    end
    e.ctrl = expCtrl; e.valid = expValid; e.cnt = expCnt; e.cnt2 = expCnt2;
    prevExp = e;
    outQ.push_back(e);
    if (chkStall) stallQ.push_back(expStall);
  endtask

  // Combinational stall monitor, sampled after the new inputs settle
  initial forever begin
    @(negedge clk);
    #2;
    if (stallQ.size() != 0) begin
      bit s;
      s = stallQ.pop_front();
      checkOutput("load_use_stall", 32'(stall), 32'(s));
      checkOutput("load_use_stall_sat", 32'(stall2), 32'(s));
    end
  end

  // Registered output monitor, sampled just after the capturing edge
  initial forever begin
    @(posedge clk);
    #1;
    if (outQ.size() != 0) begin
      exp_t e;
      e = outQ.pop_front();
      checkOutput("ex_ctrl", 32'(exCtrl), 32'(e.ctrl));
      checkOutput("ex_valid", 32'(exValid), 32'(e.valid));
      checkOutput("ex_rd1", 32'(exRd1), 32'(e.rd1));
      checkOutput("ex_rd2", 32'(exRd2), 32'(e.rd2));
      checkOutput("ex_imm", 32'(exImm), 32'(e.imm));
      checkOutput("ex_pc1", 32'(exPc1), 32'(e.pc1));
      checkOutput("ex_rs", 32'(exRs), 32'(e.rs));
      checkOutput("ex_rt", 32'(exRt), 32'(e.rt));
      checkOutput("ex_rd", 32'(exRd), 32'(e.rd));
      checkOutput("bubble_cnt", 32'(cnt), 32'(e.cnt));
      checkOutput("bubble_cnt_sat", 32'(cnt2), 32'(e.cnt2));
    end
  end

  // Directed sequence
  initial begin
    logic [1:0] satSeq [5];
    int waitCycles;
    satSeq[0] = 2'd1; satSeq[1] = 2'd2; satSeq[2] = 2'd3; satSeq[3] = 2'd3; satSeq[4] = 2'd3;

    // reset with random inputs
    applyStimulus(1,0,0,1, '0,0,0,0,0,16'h0, 0,0, '0,0,16'd0,2'd0);
    applyStimulus(1,0,0,1, '0,0,0,0,0,16'h0, 1,0, '0,0,16'd0,2'd0);
    // basic capture; this bundle has MemRead set with rt=3
    applyStimulus(0,0,0,0, 9'b011110011,1,3,4,1,16'h1234, 1,0, 9'b011110011,1,16'd0,2'd0);
    applyStimulus(0,0,0,0, ALU,5,6,7,1,16'h2222, 1,0, ALU,1,16'd0,2'd0);
    // load rt=2 then consumer on rs=2: one bubble then advance
    applyStimulus(0,0,0,0, LD,1,2,0,1,16'h3333, 1,0, LD,1,16'd0,2'd0);
    applyStimulus(0,0,0,0, ALU,2,5,6,1,16'h4444, 1,1, '0,0,16'd1,2'd1);
    applyStimulus(0,0,0,0, ALU,2,5,6,1,16'h4444, 1,0, ALU,1,16'd1,2'd1);
    // rt match without use of rt, and load to r0: no hazard
    applyStimulus(0,0,0,0, LD,0,2,0,1,16'h5555, 1,0, LD,1,16'd1,2'd1);
    applyStimulus(0,0,0,0, ALU,4,2,3,0,16'h6666, 1,0, ALU,1,16'd1,2'd1);
    applyStimulus(0,0,0,0, LD,1,0,0,1,16'h7777, 1,0, LD,1,16'd1,2'd1);
    applyStimulus(0,0,0,0, ALU,0,0,5,1,16'h8888, 1,0, ALU,1,16'd1,2'd1);
    // flush overrides a live hazard
    applyStimulus(0,0,0,0, LD,1,3,0,1,16'h9999, 1,0, LD,1,16'd1,2'd1);
    applyStimulus(0,0,1,0, ALU,3,4,5,1,16'hAAAA, 1,0, '0,0,16'd1,2'd1);
    // hold freezes everything while the stall still reports the hazard
    applyStimulus(0,0,0,0, LD,1,7,0,1,16'hBBBB, 1,0, LD,1,16'd1,2'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus(0,1,0,0, ALU,7,1,2,1,16'hCCCC, 1,1, LD,1,16'd1,2'd1);
    applyStimulus(0,0,0,0, ALU,7,1,2,1,16'hCCCC, 1,1, '0,0,16'd2,2'd2);
    applyStimulus(0,0,0,0, ALU,7,1,2,1,16'hCCCC, 1,0, ALU,1,16'd2,2'd2);
    // fresh reset then five load-use pairs to show saturation of the narrow counter
    applyStimulus(1,0,0,1, '0,0,0,0,0,16'h0, 0,0, '0,0,16'd0,2'd0);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(0,0,0,0, LD,0,1,0,1,16'h1000 + 16'(p), 1,0, LD,1,16'(p),
                    (p == 0) ? 2'd0 : satSeq[p-1]);
      applyStimulus(0,0,0,0, ALU,1,2,3,1,16'h2000 + 16'(p), 1,1, '0,0,16'(p+1), satSeq[p]);
      applyStimulus(0,0,0,0, ALU,1,2,3,1,16'h2000 + 16'(p), 1,0, ALU,1,16'(p+1), satSeq[p]);
    end
    // reset wins even in the middle of a hazard
    applyStimulus(0,0,0,0, LD,0,1,0,1,16'h3000, 1,0, LD,1,16'd5,2'd3);
    applyStimulus(1,0,0,0, ALU,1,2,3,1,16'h3001, 1,1, '0,0,16'd0,2'd0);
    applyStimulus(0,0,0,0, ALU,1,2,3,1,16'h3002, 1,0, ALU,1,16'd0,2'd0);

    waitCycles = 0;
    while ((outQ.size() != 0 || stallQ.size() != 0) && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    repeat (2) @(posedge clk);
    assertCount++;
    if (outQ.size() != 0 || stallQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", outQ.size() + stallQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
